bird_flock_renderer: RTL and testbench

Parametrised multi-bird sprite engine for the duck hunt VGA path. It owns the position and wing phase of up to NUM_BIRDS birds and runs an internal frame divider. Every STEP_FRAMES frames it performs one sweep: for each bird, erase at the old position, advance x by one, then redraw with flapping wings. The pixel stream it emits (x_out, y_out, colour, plot) feeds vga_adapter directly; plot_ready provides back-pressure.

---
 rtl/bird_flock_renderer_pkg.sv | 50 +++++
 rtl/bird_flock_renderer_if.sv | 48 ++++
 rtl/bird_flock_renderer_sprite_offset.sv | 30 +++
 rtl/bird_flock_renderer.sv | 195 +++++++++++++++++++
 tb/tb_bird_flock_renderer.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bird_flock_renderer_pkg.sv
// bird_flock_renderer_pkg
// Shared definitions for the bird sprite engine:
//   - screen and colour defaults
//   - sprite size and the (dx,dy) offset tables for body and both wing sets
//   - FSM state encoding and the slot-entry decision helper
//   - id_width(): slot index width for a given bird count
package bird_flock_renderer_pkg;

   localparam int         DEF_SCREEN_W    = 160;
   localparam int         DEF_SCREEN_H    = 120;
   localparam logic [2:0] DEF_BIRD_COLOUR = 3'b111;
   localparam logic [2:0] DEF_BG_COLOUR   = 3'b000;

   localparam int SPRITE_PIXELS = 10;
   localparam int BODY_PIXELS   = 7;
   localparam int WING_PIXELS   = 3;

   // Body: (0,0) (0,+1) (-1,0) .. (-5,0), relative to the bird's anchor
   localparam logic signed [3:0] BODY_DX [0:6] =
      '{4'sd0, 4'sd0, -4'sd1, -4'sd2, -4'sd3, -4'sd4, -4'sd5};
   localparam logic signed [3:0] BODY_DY [0:6] =
      '{4'sd0, 4'sd1, 4'sd0, 4'sd0, 4'sd0, 4'sd0, 4'sd0};

   // Both wing sets share their x offsets; only the y direction flips
   localparam logic signed [3:0] WING_DX    [0:2] = '{-4'sd3, -4'sd4, -4'sd5};
   localparam logic signed [3:0] WING_UP_DY [0:2] = '{4'sd1, 4'sd2, 4'sd3};
   localparam logic signed [3:0] WING_DN_DY [0:2] = '{-4'sd1, -4'sd2, -4'sd3};

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ERASE = 3'd1,
      ST_MOVE  = 3'd2,
      ST_DRAW  = 3'd3,
      ST_NEXT  = 3'd4
   } state_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // First state for a slot: anything on screen is erased first; a live bird
   // that is not yet on screen is drawn without moving; empty slots only pass
   // through NEXT.
   function automatic state_t entry_state(input logic alive, input logic visible);
      if (visible)   return ST_ERASE;
      else if (alive) return ST_DRAW;
      else            return ST_NEXT;
   endfunction

endpackage

// File: rtl/bird_flock_renderer_if.sv
// bird_flock_renderer_if
// Bundles the control and pixel-stream signals of bird_flock_renderer.
//   master : the controller / VGA sink side (drives spawn, kill, plot_ready)
//   slave  : the renderer itself
// Signals:
//   spawn_valid/spawn_id/spawn_x/spawn_y, kill_valid/kill_id -> commands
//   spawn_ready   <- renderer idle, commands accepted
//   plot_ready    -> sink accepts the current pixel
//   x_out/y_out/colour/plot <- pixel stream
//   busy/frame_done/tick_overrun <- sweep status
//   state         <- FSM state, for observation only
//
// Handshakes: a command transfers on a clock edge where its valid and
// spawn_ready are both high; a pixel transfers on an edge where plot and
// plot_ready are both high. While plot is high and plot_ready is low the
// pixel outputs hold their values until the transfer happens.
interface bird_flock_renderer_if
   import bird_flock_renderer_pkg::*;
#(
   parameter int ID_W = 3
) ();
   logic            spawn_valid;
   logic [ID_W-1:0] spawn_id;
   logic [7:0]      spawn_x;
   logic [6:0]      spawn_y;
   logic            kill_valid;
   logic [ID_W-1:0] kill_id;
   logic            spawn_ready;
   logic            plot_ready;
   logic [7:0]      x_out;
   logic [6:0]      y_out;
   logic [2:0]      colour;
   logic            plot;
   logic            busy;
   logic            frame_done;
   logic            tick_overrun;
   state_t          state;

   modport master (
      output spawn_valid, spawn_id, spawn_x, spawn_y, kill_valid, kill_id, plot_ready,
      input  spawn_ready, x_out, y_out, colour, plot, busy, frame_done, tick_overrun, state
   );

   modport slave (
      input  spawn_valid, spawn_id, spawn_x, spawn_y, kill_valid, kill_id, plot_ready,
      output spawn_ready, x_out, y_out, colour, plot, busy, frame_done, tick_overrun, state
   );
endinterface

// File: rtl/bird_flock_renderer_sprite_offset.sv
// bird_sprite_offset
// Combinational lookup of one sprite pixel's offset from the bird anchor.
//   pix_idx : pixel index 0..9 (0..6 body, 7..9 wings)
//   wing_up : wing phase to render
//   dx, dy  : signed offsets; indices outside 0..9 give (0,0)
module bird_sprite_offset
   import bird_flock_renderer_pkg::*;
(
   input  logic [3:0]        pix_idx,
   input  logic              wing_up,
   output logic signed [3:0] dx,
   output logic signed [3:0] dy
);
   always_comb begin
      dx = '0;
      dy = '0;
      for (int i = 0; i < BODY_PIXELS; i++) begin
         if (pix_idx == 4'(i)) begin
            dx = BODY_DX[i];
            dy = BODY_DY[i];
         end
      end
      for (int i = 0; i < WING_PIXELS; i++) begin
         if (pix_idx == 4'(BODY_PIXELS + i)) begin
            dx = WING_DX[i];
            dy = wing_up ? WING_UP_DY[i] : WING_DN_DY[i];
         end
      end
   end
endmodule

// File: rtl/bird_flock_renderer.sv
// bird_flock_renderer
// Multi-bird sprite engine for the duck hunt VGA path. Holds position, alive
// and visible flags per slot plus a global wing phase. A frame divider issues
// a sweep tick every STEP_FRAMES frames; each sweep walks all slots, erasing
// the old sprite, stepping x by one and redrawing with the other wing phase.
// Ports:
//   CLOCK_50 : system clock
//   reset    : synchronous, active-high
//   bus      : bird_flock_renderer_if slave (commands, pixel stream, status)
module bird_flock_renderer
   import bird_flock_renderer_pkg::*;
#(
   parameter int         NUM_BIRDS    = 6,
   parameter int         SCREEN_W     = DEF_SCREEN_W,
   parameter int         SCREEN_H     = DEF_SCREEN_H,
   parameter int         FRAME_CYCLES = 833333,
   parameter int         STEP_FRAMES  = 1,
   parameter logic [2:0] BIRD_COLOUR  = DEF_BIRD_COLOUR,
   parameter logic [2:0] BG_COLOUR    = DEF_BG_COLOUR
) (
   input  logic                 CLOCK_50,
   input  logic                 reset,
   bird_flock_renderer_if.slave bus
);
   localparam int              ID_W      = id_width(NUM_BIRDS);
   localparam int              DIV_W     = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [ID_W-1:0] LAST_SLOT = ID_W'(NUM_BIRDS - 1);

   // Slot storage and global wing phase
   logic [7:0]           pos_x [NUM_BIRDS];
   logic [6:0]           pos_y [NUM_BIRDS];
   logic [NUM_BIRDS-1:0] alive;
   logic [NUM_BIRDS-1:0] visible;
   logic                 wing_up;

   // Sweep walker
   state_t          state, state_nxt;
   logic [ID_W-1:0] slot, slot_inc;
   logic [3:0]      pix;

   // Frame divider
   logic [DIV_W-1:0] div_cnt;
   logic [5:0]       step_cnt;
   logic             frame_tick, sweep_tick;
   logic             overrun;

   // Pixel datapath
   logic [7:0]        cur_x;
   logic [6:0]        cur_y;
   logic              phase;
   logic signed [3:0] dx, dy;
   logic [8:0]        px, py;
   logic              in_pixel, on_screen, advance, last_pix, cmd_ready;

   assign slot_inc  = slot + ID_W'(1);
   assign cur_x     = pos_x[slot];
   assign cur_y     = pos_y[slot];
   assign cmd_ready = (state == ST_IDLE) && !reset;

   // Erase must use the phase the sprite was drawn with, i.e. last sweep's
   assign phase = (state == ST_ERASE) ? ~wing_up : wing_up;

   bird_sprite_offset u_offset (
      .pix_idx (pix),
      .wing_up (phase),
      .dx      (dx),
      .dy      (dy)
   );

   // 9-bit two's complement: anchor (0..255) plus offset (-5..+3) never
   // overflows, so bit 8 is the sign.
   assign px        = {1'b0, cur_x} + {{5{dx[3]}}, dx};
   assign py        = {2'b00, cur_y} + {{5{dy[3]}}, dy};
   assign on_screen = !px[8] && (px < 9'(SCREEN_W)) && !py[8] && (py < 9'(SCREEN_H));
   assign in_pixel  = (state == ST_ERASE) || (state == ST_DRAW);
   // Clipped pixels never wait on the sink
   assign advance   = in_pixel && (!on_screen || bus.plot_ready);
   assign last_pix  = (pix == 4'(SPRITE_PIXELS - 1));

   assign frame_tick = (div_cnt == DIV_W'(FRAME_CYCLES - 1));
   assign sweep_tick = frame_tick && (step_cnt == 6'(STEP_FRAMES - 1));

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         div_cnt  <= '0;
         step_cnt <= '0;
         overrun  <= 1'b0;
      end else begin
         if (frame_tick) begin
            div_cnt  <= '0;
            step_cnt <= (step_cnt == 6'(STEP_FRAMES - 1)) ? 6'd0 : step_cnt + 6'd1;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
         if (sweep_tick && (state != ST_IDLE)) overrun <= 1'b1;
      end
   end

   // FSM: state register
   always_ff @(posedge CLOCK_50) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (sweep_tick) state_nxt = entry_state(alive[0], visible[0]);
         ST_ERASE: if (advance && last_pix) state_nxt = alive[slot] ? ST_MOVE : ST_NEXT;
         ST_MOVE:  state_nxt = ST_DRAW;
         ST_DRAW:  if (advance && last_pix) state_nxt = ST_NEXT;
         ST_NEXT:  begin
            if (slot == LAST_SLOT) state_nxt = ST_IDLE;
            else                   state_nxt = entry_state(alive[slot_inc], visible[slot_inc]);
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // FSM: outputs (decoded from registered state; zero while reset is high)
   always_comb begin
      bus.plot         = 1'b0;
      bus.x_out        = '0;
      bus.y_out        = '0;
      bus.colour       = '0;
      bus.busy         = 1'b0;
      bus.frame_done   = 1'b0;
      bus.spawn_ready  = cmd_ready;
      bus.tick_overrun = overrun;
      bus.state        = state;
      if (!reset) begin
         bus.busy       = (state != ST_IDLE);
         bus.frame_done = (state == ST_NEXT) && (slot == LAST_SLOT);
         if (in_pixel && on_screen) begin
            bus.plot   = 1'b1;
            bus.x_out  = px[7:0];
            bus.y_out  = py[6:0];
            bus.colour = (state == ST_DRAW) ? BIRD_COLOUR : BG_COLOUR;
         end
      end
   end

   // Slot storage, pixel counter and slot walker
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         slot    <= '0;
         pix     <= '0;
         wing_up <= 1'b1;
         alive   <= '0;
         visible <= '0;
         for (int i = 0; i < NUM_BIRDS; i++) begin
            pos_x[i] <= '0;
            pos_y[i] <= '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               slot <= '0;
               pix  <= '0;
               if (cmd_ready && bus.spawn_valid) begin
                  pos_x[bus.spawn_id]   <= bus.spawn_x;
                  pos_y[bus.spawn_id]   <= bus.spawn_y;
                  alive[bus.spawn_id]   <= 1'b1;
                  visible[bus.spawn_id] <= 1'b0;
               end
               // Placed after spawn so kill wins on the same slot
               if (cmd_ready && bus.kill_valid) alive[bus.kill_id] <= 1'b0;
            end
            ST_ERASE, ST_DRAW: begin
               if (advance) begin
                  pix <= last_pix ? 4'd0 : pix + 4'd1;
                  // Drawing leaves the bird on screen; erasing a dead bird
                  // takes it off for good.
                  if (last_pix && ((state == ST_DRAW) || !alive[slot]))
                     visible[slot] <= (state == ST_DRAW);
               end
            end
            ST_MOVE: begin
               pos_x[slot] <= (cur_x + 8'd1 == 8'(SCREEN_W)) ? 8'd0 : cur_x + 8'd1;
            end
            ST_NEXT: begin
               if (slot == LAST_SLOT) begin
                  slot    <= '0;
                  wing_up <= ~wing_up;
               end else begin
                  slot <= slot_inc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bird_flock_renderer.sv
// tb_bird_flock_renderer
// Self-checking bench for bird_flock_renderer: directed scenarios followed by
// randomized spawn/kill traffic and random sink back-pressure, all checked
// against a sweep-level behavioural model.
module tb_bird_flock_renderer;
   localparam int NB = 3;
   localparam int FC = 100;
   localparam int SF = 2;
   localparam int SW = 160;
   localparam int SH = 120;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bird_flock_renderer_if #(.ID_W(2)) bus ();

   bird_flock_renderer #(
      .NUM_BIRDS    (NB),
      .SCREEN_W     (SW),
      .SCREEN_H     (SH),
      .FRAME_CYCLES (FC),
      .STEP_FRAMES  (SF),
      .BIRD_COLOUR  (3'b111),
      .BG_COLOUR    (3'b000)
   ) dut (
      .CLOCK_50 (clk),
      .reset    (rst),
      .bus      (bus)
   );

   // Behavioural model: bird table, wing phase, expected pixel queue
   int          m_x [NB];
   int          m_y [NB];
   bit          m_alive [NB];
   bit          m_vis [NB];
   bit          m_wing;
   int          last_start;
   logic [17:0] exp_q [$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int off_dx(input int k);
      return (k < 2) ? 0 : (k < 7) ? 1 - k : 4 - k;
   endfunction

   function automatic int off_dy(input int k, input bit up);
      if (k == 1) return 1;
      if (k < 7)  return 0;
      return up ? k - 6 : 6 - k;
   endfunction

   task automatic model_clear();
      for (int s = 0; s < NB; s++) begin
         m_x[s] = 0; m_y[s] = 0; m_alive[s] = 0; m_vis[s] = 0;
      end
      m_wing = 1;
      last_start = -1;
      exp_q.delete();
   endtask

   task automatic push_sprite(input int s, input logic [2:0] c, input bit up);
      int px, py;
      for (int k = 0; k < 10; k++) begin
         px = m_x[s] + off_dx(k);
         py = m_y[s] + off_dy(k, up);
         if (px >= 0 && px < SW && py >= 0 && py < SH)
            exp_q.push_back({8'(px), 7'(py), c});
      end
   endtask

   // Queue every pixel the coming sweep should plot, update the model to its
   // post-sweep state and return the nominal cycle count (no stalls).
   task automatic build_expected(output int len);
      len = 0;
      for (int s = 0; s < NB; s++) begin
         if (m_vis[s]) begin
            push_sprite(s, 3'd0, !m_wing);
            len += 10;
            if (m_alive[s]) begin
               m_x[s] = (m_x[s] + 1 == SW) ? 0 : (m_x[s] + 1) % 256;
               push_sprite(s, 3'd7, m_wing);
               len += 11;
            end else begin
               m_vis[s] = 0;
            end
         end else if (m_alive[s]) begin
            push_sprite(s, 3'd7, m_wing);
            m_vis[s] = 1;
            len += 10;
         end
         len += 1;
      end
      m_wing = !m_wing;
   endtask

   // Issue one command cycle; called at a negedge while idle
   task automatic cmd(input bit sp, input bit kl, input int id, input int x, input int y);
      check_eq("spawn_ready", bus.spawn_ready, 1);
      bus.spawn_valid = sp;
      bus.kill_valid  = kl;
      bus.spawn_id    = 2'(id);
      bus.kill_id     = 2'(id);
      bus.spawn_x     = 8'(x);
      bus.spawn_y     = 7'(y);
      @(negedge clk);
      bus.spawn_valid = 1'b0;
      bus.kill_valid  = 1'b0;
      if (sp) begin
         m_x[id] = x; m_y[id] = y; m_alive[id] = 1; m_vis[id] = 0;
      end
      if (kl) m_alive[id] = 0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      bus.spawn_valid = 1'b0;
      bus.kill_valid  = 1'b0;
      bus.plot_ready  = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("rst_plot", bus.plot, 0);
      check_eq("rst_x", bus.x_out, 0);
      check_eq("rst_y", bus.y_out, 0);
      check_eq("rst_colour", bus.colour, 0);
      check_eq("rst_busy", bus.busy, 0);
      check_eq("rst_done", bus.frame_done, 0);
      check_eq("rst_overrun", bus.tick_overrun, 0);
      check_eq("rst_spawn_ready", bus.spawn_ready, 0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("post_rst_ready", bus.spawn_ready, 1);
      check_eq("post_rst_overrun", bus.tick_overrun, 0);
      check_eq("post_rst_busy", bus.busy, 0);
      model_clear();
   endtask

   // mode 0: random plot_ready; 1: one 5-cycle stall on draw pixel 4; 2: always ready
   task automatic run_sweep(input int mode);
      int   guard, len, stalls, exp_len, draw_xfers, stall_left;
      bit   done, held, rdy;
      logic [7:0]  h_x;
      logic [6:0]  h_y;
      logic [2:0]  h_c;
      logic [17:0] e;
      guard = 0;
      bus.plot_ready = 1'b1;
      while (!bus.busy && guard < 2 * FC * SF + 20) begin
         @(negedge clk);
         guard++;
      end
      check_eq("sweep_start", bus.busy, 1);
      if (!bus.busy) return;
      if (last_start >= 0) check_eq("sweep_period", cyc - last_start, FC * SF);
      last_start = cyc;
      build_expected(exp_len);
      len = 0; stalls = 0; done = 0; held = 0; draw_xfers = 0; stall_left = 5;
      h_x = '0; h_y = '0; h_c = '0;
      while (!done && len < 600) begin
         if (held) begin
            check_eq("hold_plot", bus.plot, 1);
            check_eq("hold_x", bus.x_out, h_x);
            check_eq("hold_y", bus.y_out, h_y);
            check_eq("hold_colour", bus.colour, h_c);
         end
         len++;
         case (mode)
            0:       rdy = ($urandom_range(0, 3) != 0);
            1:       rdy = !(bus.plot && bus.colour == 3'd7 && draw_xfers == 4 && stall_left > 0);
            default: rdy = 1'b1;
         endcase
         if (!rdy && mode == 1) stall_left--;
         bus.plot_ready = rdy;
         held = 0;
         if (bus.plot) begin
            if (rdy) begin
               if (bus.colour == 3'd7) draw_xfers++;
               if (exp_q.size() == 0) begin
                  check_eq("extra_plot", bus.plot, 0);
               end else begin
                  e = exp_q.pop_front();
                  check_eq("pix_x", bus.x_out, e[17:10]);
                  check_eq("pix_y", bus.y_out, e[9:3]);
                  check_eq("pix_colour", bus.colour, e[2:0]);
               end
            end else begin
               stalls++;
               held = 1;
               h_x = bus.x_out; h_y = bus.y_out; h_c = bus.colour;
            end
         end
         if (bus.frame_done) done = 1;
         else @(negedge clk);
      end
      check_eq("sweep_len", len, exp_len + stalls);
      check_eq("plots_left", exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
      bus.plot_ready = 1'b1;
      check_eq("idle_after", bus.busy, 0);
      check_eq("done_pulse", bus.frame_done, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int g, nops, op, id, x, y;
      bus.spawn_valid = 1'b0;
      bus.kill_valid  = 1'b0;
      bus.spawn_id    = '0;
      bus.kill_id     = '0;
      bus.spawn_x     = '0;
      bus.spawn_y     = '0;
      bus.plot_ready  = 1'b1;
      model_clear();
      apply_reset();

      // First draw, then erase/move/redraw with the opposite wings
      cmd(1, 0, 0, 20, 10);
      run_sweep(2);
      run_sweep(2);

      // Right-edge bird wraps to x=0 and is mostly clipped
      cmd(1, 0, 1, 159, 10);
      run_sweep(2);
      run_sweep(2);

      // Five-cycle back-pressure in the middle of a draw
      run_sweep(1);

      // Killed bird: one erase-only sweep, then nothing
      cmd(0, 1, 0, 0, 0);
      run_sweep(2);
      run_sweep(2);

      // Same-slot spawn and kill: kill wins
      cmd(1, 1, 2, 40, 40);
      run_sweep(2);

      // Randomized traffic under random back-pressure
      for (int it = 0; it < 14; it++) begin
         nops = $urandom_range(0, 2);
         for (int k = 0; k < nops; k++) begin
            op = $urandom_range(0, 3);
            id = $urandom_range(0, NB - 1);
            x  = $urandom_range(0, 199);
            y  = $urandom_range(0, 127);
            cmd(op != 1, op == 1 || op == 2, id, x, y);
         end
         run_sweep(0);
      end

      // Reset in the middle of a draw
      cmd(1, 0, 2, 50, 60);
      g = 0;
      while (!(bus.plot && bus.colour == 3'd7) && g < 2 * FC * SF + 40) begin
         @(negedge clk);
         g++;
      end
      check_eq("draw_seen", bus.plot && bus.colour == 3'd7, 1);
      rst = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_plot", bus.plot, 0);
      check_eq("mid_rst_busy", bus.busy, 0);
      apply_reset();
      run_sweep(2);

      // Sweep tick while stalled sets the sticky overrun flag
      cmd(1, 0, 0, 30, 30);
      check_eq("ovr_clear", bus.tick_overrun, 0);
      bus.plot_ready = 1'b0;
      g = 0;
      while (!bus.busy && g < 2 * FC * SF + 20) begin
         @(negedge clk);
         g++;
      end
      repeat (FC * SF + 10) @(negedge clk);
      check_eq("ovr_set", bus.tick_overrun, 1);
      check_eq("ovr_busy", bus.busy, 1);
      check_eq("ovr_plot_held", bus.plot, 1);
      bus.plot_ready = 1'b1;
      repeat (30) @(negedge clk);
      check_eq("ovr_sticky", bus.tick_overrun, 1);
      check_eq("ovr_idle", bus.busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
